// File: rtl/rag_aug_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the augmented-context writer/reader pair.
package rag_aug_pkg;

  localparam logic [7:0] SEP_BYTE = 8'h0A;
  localparam int         SEP_LEN  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_FLUSH,
    ST_CLOSE,
    ST_DONE
  } split_state_t;

  typedef enum logic [1:0] {
    CLS_DATA,
    CLS_SEP,
    CLS_FLUSH_NL_THEN_DATA,
    CLS_PEND
  } byte_cls_t;

  // Width of a segment id able to hold 0..top_k (query plus top_k documents).
  function automatic int seg_id_width(input int top_k);
    return (top_k < 1) ? 1 : $clog2(top_k + 1);
  endfunction

endpackage

// File: rtl/augmented_text_splitter_sep_detector.sv
`timescale 1ns/1ps
// Pending-newline tracker: classifies each accepted byte against the
// two-byte separator.
module sep_detector
  import rag_aug_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       accept,
  input  logic       last,
  input  logic [7:0] data,
  output byte_cls_t  cls
);

  logic pending;
  logic is_sep;

  assign is_sep = (data == SEP_BYTE);

  // Classification of the byte currently offered, given the pending newline.
  always_comb begin
    cls = CLS_DATA;
    if (is_sep) cls = pending ? CLS_SEP : CLS_PEND;
    else if (pending) cls = CLS_FLUSH_NL_THEN_DATA;
  end

  // A lone newline on the final byte is flushed as payload, so nothing stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= 1'b0;
    else if (clear) pending <= 1'b0;
    else if (accept) pending <= (cls == CLS_PEND) && !last;
  end

endmodule

// File: rtl/augmented_text_splitter.sv
`timescale 1ns/1ps
// Splits an augmented context stream (query "\n\n" doc0 "\n\n" ...) into
// tagged payload bytes plus one descriptor per segment.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting input bytes
// HOLD  | lone '\n' was loaded, held byte goes out next
// FLUSH | trailing lone '\n' at end of stream goes out
// CLOSE | descriptor presented once out is empty, wait desc_ready
// DONE  | wait for out to drain, pulse done
module augmented_text_splitter
  import rag_aug_pkg::*;
#(
  parameter  int MAX_SEQUENCE_LEN = 512,
  parameter  int TOP_K            = 5,
  localparam int IDW              = seg_id_width(TOP_K),
  localparam int CW               = $clog2(TOP_K + 2)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           done,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_data,
  output logic [IDW-1:0] out_seg_id,
  output logic           desc_valid,
  input  logic           desc_ready,
  output logic [IDW-1:0] desc_seg_id,
  output logic [31:0]    desc_start,
  output logic [31:0]    desc_len,
  output logic [CW-1:0]  seg_count,
  output logic           err_too_many_segs,
  output logic           err_seg_overflow
);

  split_state_t   state, state_d;
  byte_cls_t      cls;
  logic           accept, slot_free, room, arm;
  logic           emit, hold_ld, last_set, drop_set, sep_seen;
  logic           desc_ld, close_done, done_d;
  logic [7:0]     emit_byte, hold_byte;
  logic           last_r;
  logic [31:0]    byte_cnt, seg_len, seg_start, nxt_start;
  logic [IDW-1:0] seg_id;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == ST_RUN) && slot_free && !desc_valid;
  assign accept    = in_valid && in_ready;
  assign room      = seg_len < 32'(MAX_SEQUENCE_LEN);
  assign arm       = (state == ST_IDLE) && start;

  sep_detector u_sep (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (arm),
    .accept (accept),
    .last   (in_last),
    .data   (in_data),
    .cls    (cls)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state and per-cycle datapath strobes. Once too many segments are
  // seen (err_too_many_segs), the rest of the stream is swallowed.
  always_comb begin
    state_d    = state;
    emit       = 1'b0;
    emit_byte  = in_data;
    hold_ld    = 1'b0;
    last_set   = 1'b0;
    drop_set   = 1'b0;
    sep_seen   = 1'b0;
    desc_ld    = 1'b0;
    close_done = 1'b0;
    done_d     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (accept) begin
          if (err_too_many_segs) begin
            if (in_last) state_d = ST_DONE;
          end else begin
            case (cls)
              CLS_DATA: begin
                emit = 1'b1;
                if (in_last) begin
                  last_set = 1'b1;
                  state_d  = ST_CLOSE;
                end
              end
              CLS_PEND: begin
                if (in_last) begin
                  last_set = 1'b1;
                  state_d  = ST_FLUSH;
                end
              end
              CLS_SEP: begin
                sep_seen = 1'b1;
                state_d  = ST_CLOSE;
                if (in_last) last_set = 1'b1;
                else if (seg_id == IDW'(TOP_K)) drop_set = 1'b1;
              end
              default: begin
                emit      = 1'b1;
                emit_byte = SEP_BYTE;
                hold_ld   = 1'b1;
                state_d   = ST_HOLD;
                if (in_last) last_set = 1'b1;
              end
            endcase
          end
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_byte = hold_byte;
          state_d   = last_r ? ST_CLOSE : ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_byte = SEP_BYTE;
          state_d   = ST_CLOSE;
        end
      end
      ST_CLOSE: begin
        if (!desc_valid && !out_valid) begin
          desc_ld = 1'b1;
        end else if (desc_valid && desc_ready) begin
          close_done = 1'b1;
          state_d    = last_r ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        if (!out_valid && !desc_valid) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers, segment bookkeeping and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done              <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_seg_id        <= '0;
      desc_valid        <= 1'b0;
      desc_seg_id       <= '0;
      desc_start        <= '0;
      desc_len          <= '0;
      seg_count         <= '0;
      err_too_many_segs <= 1'b0;
      err_seg_overflow  <= 1'b0;
      hold_byte         <= '0;
      last_r            <= 1'b0;
      byte_cnt          <= '0;
      seg_len           <= '0;
      seg_start         <= '0;
      nxt_start         <= '0;
      seg_id            <= '0;
    end else begin
      done <= done_d;
      if (out_ready) out_valid <= 1'b0;
      if (emit) begin
        if (room) begin
          out_valid  <= 1'b1;
          out_data   <= emit_byte;
          out_seg_id <= seg_id;
          seg_len    <= seg_len + 32'd1;
        end else begin
          err_seg_overflow <= 1'b1;
        end
      end
      if (accept)   byte_cnt  <= byte_cnt + 32'd1;
      if (hold_ld)  hold_byte <= in_data;
      if (last_set) last_r    <= 1'b1;
      if (drop_set) err_too_many_segs <= 1'b1;
      // byte_cnt is the offset of the separator's second byte here.
      if (sep_seen) nxt_start <= byte_cnt + 32'(SEP_LEN) - 32'd1;
      if (desc_ld) begin
        desc_valid  <= 1'b1;
        desc_seg_id <= seg_id;
        desc_start  <= seg_start;
        desc_len    <= seg_len;
      end
      if (close_done) begin
        desc_valid <= 1'b0;
        seg_count  <= seg_count + CW'(1);
        seg_len    <= '0;
        seg_start  <= nxt_start;
        if (!err_too_many_segs) seg_id <= seg_id + IDW'(1);
      end
      if (arm) begin
        seg_count         <= '0;
        err_too_many_segs <= 1'b0;
        err_seg_overflow  <= 1'b0;
        last_r            <= 1'b0;
        byte_cnt          <= '0;
        seg_len           <= '0;
        seg_start         <= '0;
        nxt_start         <= '0;
        seg_id            <= '0;
      end
    end
  end

endmodule

// File: doc/augmented_text_splitter.md
Name: augmented_text_splitter

Overview:
Reader-side counterpart of the augmentation buffer writer. It consumes an augmented context byte stream with the layout query, "\n\n", doc0, "\n\n", doc1, and so on. It strips the two-byte separators and re-emits payload bytes tagged with a segment id. For each segment it issues a descriptor carrying id, start offset and length. It sits between the augmented-context store and the downstream tokenizer and verification logic, and recovers query and document boundaries without a full-buffer copy.

Parameters:
MAX_SEQUENCE_LEN, 512, max payload bytes per segment; bytes beyond this are dropped and flagged.
TOP_K, 5, max documents; max segments = TOP_K+1 (query plus docs).

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle pulse; arms the block when in IDLE, ignored otherwise.
done  out  1  one-cycle pulse after the final descriptor is accepted.
in_valid / in_ready  in / out  1 / 1  input byte handshake.
in_data  in  8  input byte.
in_last  in  1  marks the final byte of the stream.
out_valid / out_ready  out / in  1 / 1  payload byte handshake.
out_data  out  8  payload byte.
out_seg_id  out  $clog2(TOP_K+1)  segment of out_data (0 = query).
desc_valid / desc_ready  out / in  1 / 1  descriptor handshake.
desc_seg_id  out  $clog2(TOP_K+1)  segment id.
desc_start  out  32  input-stream offset of the segment's first payload byte.
desc_len  out  32  payload bytes emitted for the segment, separators excluded.
seg_count  out  $clog2(TOP_K+2)  segments closed so far in this stream.
err_too_many_segs  out  1  sticky; set if more than TOP_K+1 segments are seen.
err_seg_overflow  out  1  sticky; set if a segment exceeds MAX_SEQUENCE_LEN.

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - Pending-newline flag, hold register, and the byte, segment and length counters are cleared.
  - Reset mid-stream abandons everything; no descriptor or done is produced.
- States and transitions:
  - IDLE: on start, go to RUN; clear counters and error flags.
  - RUN: accepts input bytes.
  - HOLD: output the held byte after a flushed '\n'.
  - FLUSH: output a trailing lone '\n' at end of stream.
  - CLOSE: present the descriptor and wait for desc_ready.
  - DONE: pulse done for one cycle, then return to IDLE.
- in_ready = (state==RUN) && (!out_valid || out_ready) && !desc_valid. It is independent of in_data.
- Separator rules, with 0x0A the separator byte:
  - A 0x0A with no pending newline sets pending_nl and produces no output.
  - A 0x0A with pending_nl is a separator: clear pending_nl, close the current segment (CLOSE), then seg_id+1.
  - A non-0x0A with pending_nl means a lone newline: out loads 0x0A this cycle, the byte is held, go to HOLD; the held byte is emitted in the next free out slot.
  - A non-0x0A with no pending newline is loaded directly to out.
  - A third consecutive 0x0A starts the next segment's pending_nl, so "\n\n\n" followed by X gives next-segment payload "\nX".
- Latency: one cycle from input acceptance to out_valid. The out register holds while out_valid && !out_ready.
- desc_start is latched from the input byte offset at the first accepted byte after a separator, or 0 for segment 0. It counts all input bytes, separators included.
- desc_len counts emitted payload bytes and saturates at MAX_SEQUENCE_LEN. Bytes beyond that are accepted and dropped, and err_seg_overflow is set.
- Empty segment: a leading "\n\n", or two separators back to back, gives a descriptor with desc_len=0. desc_start is the offset where payload would have begun.
- in_last handling:
  - With a data byte: emit the byte, then close the final segment, then DONE.
  - Non-0x0A with pending_nl: HOLD, then CLOSE, then DONE.
  - 0x0A with no pending newline: FLUSH emits 0x0A as payload, then CLOSE.
  - 0x0A with pending_nl: it is a separator and closes the segment; no empty trailing segment is created.
- Segment limit: if a separator would open segment TOP_K+1, set err_too_many_segs. Remaining bytes are consumed and dropped, out_seg_id holds at TOP_K, and no further descriptors are issued.
- Ordering: a segment's descriptor never precedes its last payload byte leaving the out register. done asserts only after both out and desc are drained.

Decomposition:
- Shared package rag_aug_pkg:
  - SEP_BYTE = 8'h0A and SEP_LEN = 2, shared with the writer.
  - Splitter state enum.
  - Segment-id width function.
- One natural sub-module: sep_detector.
  - Pending-newline tracker.
  - Classifies each accepted byte as DATA, SEP, FLUSH_NL_THEN_DATA, or PEND.

Test Plan:
- "Hi\n\nAB\n\nC" with last on 'C' and sinks always ready -> out "HiABC" tagged ids 0,0,1,1,2; descriptors (0,0,2), (1,4,2), (2,8,1); seg_count=3; done pulses once.
- "A\nB" then "\n\nD" -> segment 0 payload "A\nB" (len 3, 0x0A emitted via HOLD); segment 1 "D" at start 5.
- Stream begins "\n\nQ" -> descriptor (0,0,0) then (1,2,1); trailing "X\n" with last -> payload "X\n", len 2.
- 7 segments with TOP_K=5 -> 6 descriptors; err_too_many_segs=1; surplus bytes consumed and dropped; done still pulses.
- out_ready and desc_ready toggled randomly at 50% over stream 1 -> identical byte and descriptor sequence; no loss or duplication.
- Segment of 520 bytes with MAX_SEQUENCE_LEN=512 -> desc_len=512, err_seg_overflow=1. Separately, rst_n low mid-stream -> all outputs 0, no done.
